// File: rtl/pixel_plot_fifo.sv
// Pixel-plot request buffer between the HTML parser and the VGA adapter.
// Replays queued pixels as paced one-cycle write strobes and asks the parser to pause before it fills.
module pixel_plot_fifo #(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int C_W          = 3,
  parameter int DEPTH        = 16,
  parameter int PAUSE_MARGIN = 4,
  parameter int PLOT_GAP     = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic [X_W-1:0]           in_x,
  input  logic [Y_W-1:0]           in_y,
  input  logic [C_W-1:0]           in_colour,
  input  logic                     in_plot,
  output logic                     pause,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  output logic [X_W-1:0]           out_x,
  output logic [Y_W-1:0]           out_y,
  output logic [C_W-1:0]           out_colour,
  output logic                     out_plot
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = X_W + Y_W + C_W;
  localparam int GW = (PLOT_GAP > 1) ? $clog2(PLOT_GAP) : 1;
  localparam logic [AW:0]   PTR_ONE     = (AW+1)'(1);
  localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PAUSE_LEVEL = (AW+1)'(DEPTH - PAUSE_MARGIN);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(PLOT_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE     = GW'(1);
  localparam bit            USE_GAP     = (PLOT_GAP > 1);

  typedef enum logic {IDLE, GAP} state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_next, rd_next, level_next;
  logic          full, empty, push, pop;
  state_t        state, state_next;
  logic [GW-1:0] gcnt, gcnt_next;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign push  = in_plot && !full && !clear;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      gcnt  <= '0;
    end else begin
      state <= state_next;
      gcnt  <= gcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    gcnt_next  = gcnt;
    if (clear) begin
      state_next = IDLE;
      gcnt_next  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty && USE_GAP) begin
            state_next = GAP;
            gcnt_next  = GAP_LOAD;
          end
        end
        GAP: begin
          if (gcnt == GAP_ONE) state_next = IDLE;
          else                 gcnt_next  = gcnt - GAP_ONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    pop = (state == IDLE) && !empty && !clear;
  end

  // Pause is registered from the next level so the parser never sees a comparator glitch.
  always_comb begin
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    if (clear) begin
      wr_next = '0;
      rd_next = '0;
    end else begin
      if (push) wr_next = wr_ptr + PTR_ONE;
      if (pop)  rd_next = rd_ptr + PTR_ONE;
    end
    level_next = wr_next - rd_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pause    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      pause  <= (level_next >= PAUSE_LEVEL);
      if (clear)                overflow <= 1'b0;
      else if (in_plot && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_x, in_y, in_colour};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_x      <= '0;
      out_y      <= '0;
      out_colour <= '0;
      out_plot   <= 1'b0;
    end else if (clear) begin
      out_plot <= 1'b0;
    end else if (pop) begin
      {out_x, out_y, out_colour} <= mem[rd_ptr[AW-1:0]];
      out_plot                   <= 1'b1;
    end else begin
      out_plot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_plot_fifo.sv
// Bench for pixel_plot_fifo: two instances (PLOT_GAP 2 and 1) share stimulus and are
// compared every cycle against a queue-based reference model.
module tb_pixel_plot_fifo;
  typedef logic [17:0] pix_t;

  logic       clock, resetn, clear, in_plot;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;

  logic       pause_a, ovf_a, plot_a, pause_b, ovf_b, plot_b;
  logic [4:0] level_a, level_b;
  logic [7:0] ox_a, ox_b;
  logic [6:0] oy_a, oy_b;
  logic [2:0] oc_a, oc_b;
  logic [25:0] act_a, act_b;

  int tests = 0;
  int fails = 0;

  pix_t mq0[$];
  pix_t mq1[$];
  int   mcool[2];
  bit   movf[2];
  bit   mplot[2];
  pix_t mout[2];

  assign act_a = {plot_a, ox_a, oy_a, oc_a, level_a, pause_a, ovf_a};
  assign act_b = {plot_b, ox_b, oy_b, oc_b, level_b, pause_b, ovf_b};

  pixel_plot_fifo #(.X_W(8), .Y_W(7), .C_W(3), .DEPTH(16), .PAUSE_MARGIN(4), .PLOT_GAP(2)) dut (
    .clock(clock), .resetn(resetn), .clear(clear), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .in_plot(in_plot), .pause(pause_a), .overflow(ovf_a),
    .level(level_a), .out_x(ox_a), .out_y(oy_a), .out_colour(oc_a), .out_plot(plot_a));

  pixel_plot_fifo #(.X_W(8), .Y_W(7), .C_W(3), .DEPTH(16), .PAUSE_MARGIN(4), .PLOT_GAP(1)) dut1 (
    .clock(clock), .resetn(resetn), .clear(clear), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .in_plot(in_plot), .pause(pause_b), .overflow(ovf_b),
    .level(level_b), .out_x(ox_b), .out_y(oy_b), .out_colour(oc_b), .out_plot(plot_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_reset();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      mcool[i] = 0;
      movf[i]  = 1'b0;
      mplot[i] = 1'b0;
      mout[i]  = '0;
    end
  endfunction

  // Reference behaviour: a pixel leaves whenever the pacing cooldown has expired,
  // and a new one is accepted only if the queue was not already full before the edge.
  function automatic void model_edge();
    pix_t q[$];
    pix_t pix;
    bit   ok;
    int   g;
    pix = {in_x, in_y, in_colour};
    for (int i = 0; i < 2; i++) begin
      if (i == 0) q = mq0; else q = mq1;
      g = (i == 0) ? 2 : 1;
      if (clear) begin
        q.delete();
        movf[i]  = 1'b0;
        mcool[i] = 0;
        mplot[i] = 1'b0;
      end else begin
        ok = in_plot && (q.size() < 16);
        if (in_plot && !ok) movf[i] = 1'b1;
        if (mcool[i] == 0 && q.size() > 0) begin
          mout[i]  = q.pop_front();
          mplot[i] = 1'b1;
          mcool[i] = g - 1;
        end else begin
          mplot[i] = 1'b0;
          if (mcool[i] > 0) mcool[i] = mcool[i] - 1;
        end
        if (ok) q.push_back(pix);
      end
      if (i == 0) mq0 = q; else mq1 = q;
    end
  endfunction

  function automatic logic [25:0] exp_vec(input int i);
    int n;
    n = (i == 0) ? mq0.size() : mq1.size();
    return {mplot[i], mout[i], 5'(n), (n >= 12), movf[i]};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (!resetn) model_reset();
    else         model_edge();
    @(negedge clock);
  endtask

  task automatic rand_pixel();
    in_x      = 8'($urandom_range(0, 254));
    in_y      = 7'($urandom);
    in_colour = 3'($urandom);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    tests++;
    if (act_a !== '0) begin fails++; $display("[TB] FAIL reset_a: got %h expected 0", act_a); end
    tests++;
    if (act_b !== '0) begin fails++; $display("[TB] FAIL reset_b: got %h expected 0", act_b); end
    @(negedge clock);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_single_write();
    in_x = 8'd5; in_y = 7'd7; in_colour = 3'd3; in_plot = 1'b1;
    tick();
    in_plot = 1'b0;
    tests++;
    if (plot_a !== 1'b0 || level_a !== 5'd1) begin
      fails++; $display("[TB] FAIL single_k: plot=%b level=%0d expected plot=0 level=1", plot_a, level_a);
    end
    tick();
    tests++;
    if (plot_a !== 1'b1 || ox_a !== 8'd5 || oy_a !== 7'd7 || oc_a !== 3'd3 || level_a !== 5'd0) begin
      fails++; $display("[TB] FAIL single_k1: plot=%b x=%0d y=%0d c=%0d level=%0d expected 1,5,7,3,0",
                        plot_a, ox_a, oy_a, oc_a, level_a);
    end
    tick();
    tests++;
    if (plot_a !== 1'b0 || ox_a !== 8'd5) begin
      fails++; $display("[TB] FAIL single_after: plot=%b x=%0d expected plot=0 x=5", plot_a, ox_a);
    end
  endtask

  task automatic test_pause();
    bit seen = 1'b0;
    in_plot = 1'b1;
    for (int c = 0; c < 80 && !seen; c++) begin
      rand_pixel();
      tick();
      tests++;
      if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL pause_fill: got %h expected %h", act_a, exp_vec(0)); end
      if (pause_a) seen = 1'b1;
    end
    tests++;
    if (!seen || level_a !== 5'd12) begin
      fails++; $display("[TB] FAIL pause_rise: seen=%b level=%0d expected pause at level 12", seen, level_a);
    end
    for (int c = 0; c < 3; c++) begin
      rand_pixel();
      tick();
    end
    in_plot = 1'b0;
    for (int c = 0; c < 80 && level_a != 5'd0; c++) begin
      tick();
      tests++;
      if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL pause_drain: got %h expected %h", act_a, exp_vec(0)); end
    end
    tests++;
    if (ovf_a !== 1'b0 || level_a !== 5'd0) begin
      fails++; $display("[TB] FAIL pause_end: overflow=%b level=%0d expected 0,0", ovf_a, level_a);
    end
  endtask

  task automatic test_overflow();
    int marker_seen = 0;
    in_plot = 1'b1;
    for (int c = 0; c < 100 && level_a != 5'd16; c++) begin
      rand_pixel();
      tick();
      tests++;
      if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL ovf_fill: got %h expected %h", act_a, exp_vec(0)); end
    end
    in_x = 8'd255; in_y = 7'd127; in_colour = 3'd7;
    tick();
    in_plot = 1'b0;
    tests++;
    if (ovf_a !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b expected 1", ovf_a); end
    for (int c = 0; c < 80; c++) begin
      tick();
      tests++;
      if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL ovf_drain: got %h expected %h", act_a, exp_vec(0)); end
      if (plot_a && {ox_a, oy_a, oc_a} == 18'h3ffff) marker_seen++;
    end
    tests++;
    if (marker_seen != 0 || ovf_a !== 1'b1) begin
      fails++; $display("[TB] FAIL ovf_sticky: marker_seen=%0d overflow=%b expected 0,1", marker_seen, ovf_a);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++;
    if (ovf_a !== 1'b0) begin fails++; $display("[TB] FAIL ovf_clear: got %b expected 0", ovf_a); end
  endtask

  task automatic test_gap1();
    pix_t want;
    in_plot = 1'b1;
    for (int j = 0; j < 9; j++) begin
      if (j < 8) begin
        in_x = 8'(10 + j); in_y = 7'(j); in_colour = 3'(j);
      end else begin
        in_plot = 1'b0;
      end
      tick();
      tests++;
      if (j == 0) begin
        if (plot_b !== 1'b0) begin fails++; $display("[TB] FAIL gap1_first: plot=%b expected 0", plot_b); end
      end else begin
        want = {8'(10 + j - 1), 7'(j - 1), 3'(j - 1)};
        if (plot_b !== 1'b1 || {ox_b, oy_b, oc_b} !== want) begin
          fails++; $display("[TB] FAIL gap1_pulse %0d: plot=%b pix=%h expected 1,%h", j, plot_b, {ox_b, oy_b, oc_b}, want);
        end
      end
    end
    tick();
    tests++;
    if (plot_b !== 1'b0 || level_b !== 5'd0) begin
      fails++; $display("[TB] FAIL gap1_end: plot=%b level=%0d expected 0,0", plot_b, level_b);
    end
    for (int c = 0; c < 20; c++) tick();
    tests++;
    if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL gap1_a: got %h expected %h", act_a, exp_vec(0)); end
  endtask

  task automatic test_clear();
    int stray = 0;
    in_plot = 1'b1;
    for (int c = 0; c < 40 && level_a != 5'd6; c++) begin
      rand_pixel();
      tick();
    end
    tests++;
    if (level_a !== 5'd6) begin fails++; $display("[TB] FAIL clear_setup: level=%0d expected 6", level_a); end
    clear = 1'b1;
    rand_pixel();
    tick();
    clear = 1'b0;
    in_plot = 1'b0;
    tests++;
    if (level_a !== 5'd0 || plot_a !== 1'b0 || ovf_a !== 1'b0 || pause_a !== 1'b0) begin
      fails++; $display("[TB] FAIL clear_edge: level=%0d plot=%b ovf=%b pause=%b expected all 0",
                        level_a, plot_a, ovf_a, pause_a);
    end
    tests++;
    if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL clear_model: got %h expected %h", act_a, exp_vec(0)); end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (plot_a !== 1'b0) stray++;
    end
    tests++;
    if (stray != 0) begin fails++; $display("[TB] FAIL clear_stale: got %0d pulses expected 0", stray); end
  endtask

  task automatic test_reset_mid_burst();
    in_plot = 1'b1;
    for (int c = 0; c < 6; c++) begin
      rand_pixel();
      tick();
    end
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    tests++;
    if (act_a !== '0 || act_b !== '0) begin
      fails++; $display("[TB] FAIL reset_mid: got %h / %h expected 0", act_a, act_b);
    end
    model_reset();
    in_plot = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    in_x = 8'd9; in_y = 7'd9; in_colour = 3'd1; in_plot = 1'b1;
    tick();
    in_plot = 1'b0;
    tick();
    tests++;
    if (plot_a !== 1'b1 || ox_a !== 8'd9 || oy_a !== 7'd9 || oc_a !== 3'd1) begin
      fails++; $display("[TB] FAIL reset_resume: plot=%b x=%0d y=%0d c=%0d expected 1,9,9,1", plot_a, ox_a, oy_a, oc_a);
    end
  endtask

  task automatic test_random();
    int rate;
    for (int c = 0; c < 400; c++) begin
      case ((c / 50) % 4)
        0: rate = 30;
        1: rate = 60;
        2: rate = 90;
        default: rate = 100;
      endcase
      clear   = ($urandom_range(0, 59) == 0);
      in_plot = ($urandom_range(0, 99) < rate);
      rand_pixel();
      tick();
      tests++;
      if (act_a !== exp_vec(0)) begin fails++; $display("[TB] FAIL random_a %0d: got %h expected %h", c, act_a, exp_vec(0)); end
      tests++;
      if (act_b !== exp_vec(1)) begin fails++; $display("[TB] FAIL random_b %0d: got %h expected %h", c, act_b, exp_vec(1)); end
    end
    clear = 1'b0;
    in_plot = 1'b0;
  endtask

  initial begin
    resetn = 1'b1;
    clear = 1'b0;
    in_plot = 1'b0;
    in_x = '0; in_y = '0; in_colour = '0;
    model_reset();
    #1;
    test_reset();
    test_single_write();
    test_pause();
    test_overflow();
    test_gap1();
    test_clear();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
